// File: rtl/seq_div_pkg.sv
// seq_div_pkg -- shared definitions for the sequential divider.
//   SEQ_DIV_WIDTH : default operand/result width
//   cnt_width()   : step-counter width for a given operand width
//   SEQ_DIV_CNT_W : step-counter width for the default width
//   div_state_e   : controller states
package seq_div_pkg;

    localparam int unsigned SEQ_DIV_WIDTH = 32;

    // Wide enough to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned SEQ_DIV_CNT_W = cnt_width(SEQ_DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step -- one combinational restoring-division step.
//   rem_i [WIDTH+1] : partial remainder before the step
//   quo_i [WIDTH]   : quotient / remaining dividend bits before the step
//   div_i [WIDTH]   : divisor magnitude
//   rem_o [WIDTH+1] : partial remainder after the step
//   quo_o [WIDTH]   : quotient shift register after the step (new bit in [0])
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;

    always_comb begin
        // {rem, quo} shifted left by one; kept one bit wider so the
        // compare sees the full shifted value.
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        ge     = (rem_sh >= {2'b00, div_i});
        diff   = rem_sh[WIDTH:0] - {1'b0, div_i};
        rem_o  = ge ? diff : rem_sh[WIDTH:0];
        quo_o  = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_div.sv
// seq_div -- sequential restoring divider for the MIPS div (and optional divu).
// Optional feature macro: SEQ_DIV_DIVU_EN adds the unsigned_op input.
//   clock       : rising-edge clock
//   reset       : asynchronous active-high reset
//   start       : launch request, sampled in IDLE only
//   dividend    : numerator, captured on the accepted start edge
//   divisor     : denominator, captured on the accepted start edge
//   unsigned_op : (SEQ_DIV_DIVU_EN only) 1 = divu, operands used as-is
//   hi_out      : remainder (sign of dividend), updated only in FIX
//   lo_out      : quotient (truncated toward zero), updated only in FIX
//   done        : one-cycle pulse, results valid
//   div_zero    : one-cycle pulse with done when the divisor was zero
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_DIVU_EN
    input  logic             unsigned_op,
`endif
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    div_state_e       state_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dz_q;

    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] lo_fix;
    logic [WIDTH-1:0] hi_fix;

`ifdef SEQ_DIV_DIVU_EN
    assign signed_op = ~unsigned_op;
`else
    assign signed_op = 1'b1;
`endif

    // Magnitudes are unsigned WIDTH-bit, so the most negative value maps
    // onto itself and is then treated as 2^(WIDTH-1).
    always_comb begin
        a_neg  = signed_op & dividend[WIDTH-1];
        b_neg  = signed_op & divisor[WIDTH-1];
        a_abs  = a_neg ? -dividend : dividend;
        b_abs  = b_neg ? -divisor  : divisor;
        lo_fix = q_neg_q ? -quo_q : quo_q;
        hi_fix = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    seq_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Results are left untouched; only the flags pulse.
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            r_neg_q <= a_neg;
                            q_neg_q <= a_neg ^ b_neg;
                            quo_q   <= a_abs;
                            dvs_q   <= b_abs;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q    <= lo_fix;
                    hi_q    <= hi_fix;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div -- table-driven bench for seq_div plus reset / re-start sequences.
module tb_seq_div;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor  = '0;
`ifdef SEQ_DIV_DIVU_EN
    logic        unsigned_op = 1'b0;
`endif
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_div #(
        .WIDTH (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIV_DIVU_EN
        .unsigned_op (unsigned_op),
`endif
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .done        (done),
        .div_zero    (div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        uop;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic uop,
                                input logic [31:0] lo, input logic [31:0] hi,
                                input logic dz, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.uop = uop; v.lo = lo; v.hi = hi; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
    endtask

    // Called at a negedge. Returns the number of rising edges after the
    // accepting edge at which done was first seen (-1 if never), and leaves
    // the caller at the negedge where done is high.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        lat   = -1;
        for (int c = 0; c < 60; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        logic [31:0] got_lo;
        logic [31:0] got_hi;

        repeat (3) @(negedge clock);
        check("reset lo", lo_out, 32'h0);
        check("reset hi", hi_out, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset dz", {31'b0, div_zero}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        //            a             b             uop   lo            hi            dz  lat
        vecs.push_back(mk(32'd100,      32'd7,        1'b0, 32'h0000000E, 32'h00000002, 1'b0, 33));
        vecs.push_back(mk(32'd5,        32'd0,        1'b0, 32'h0000000E, 32'h00000002, 1'b1, 0));
        vecs.push_back(mk(32'hFFFFFF9C, 32'd7,        1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33));
        vecs.push_back(mk(32'd100,      32'hFFFFFFF9, 1'b0, 32'hFFFFFFF2, 32'h00000002, 1'b0, 33));
        vecs.push_back(mk(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, 32'h0000000E, 32'hFFFFFFFE, 1'b0, 33));
        vecs.push_back(mk(32'hFFFFFFFB, 32'd0,        1'b0, 32'h0000000E, 32'hFFFFFFFE, 1'b1, 0));
        vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'h00000000, 1'b0, 33));
        vecs.push_back(mk(32'd0,        32'd9,        1'b0, 32'h00000000, 32'h00000000, 1'b0, 33));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33));
        vecs.push_back(mk(32'h7FFFFFFF, 32'h80000000, 1'b0, 32'h00000000, 32'h7FFFFFFF, 1'b0, 33));
        vecs.push_back(mk(32'h80000000, 32'd2,        1'b0, 32'hC0000000, 32'h00000000, 1'b0, 33));
`ifdef SEQ_DIV_DIVU_EN
        vecs.push_back(mk(32'hFFFFFFFF, 32'd2,        1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 33));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33));
        vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0, 33));
        vecs.push_back(mk(32'd8,        32'd0,        1'b1, 32'h00000000, 32'h80000000, 1'b1, 0));
`endif
        vecs.push_back(mk(32'd7,        32'd100,      1'b0, 32'h00000000, 32'h00000007, 1'b0, 33));

        foreach (vecs[i]) begin
`ifdef SEQ_DIV_DIVU_EN
            unsigned_op = vecs[i].uop;
`endif
            issue(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d lo", i), lo_out, vecs[i].lo);
            check($sformatf("v%0d hi", i), hi_out, vecs[i].hi);
            check($sformatf("v%0d div_zero", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
            @(negedge clock);
            check($sformatf("v%0d done width", i), {31'b0, done}, 32'h0);
            check($sformatf("v%0d dz width", i), {31'b0, div_zero}, 32'h0);
        end
`ifdef SEQ_DIV_DIVU_EN
        unsigned_op = 1'b0;
`endif

        // Reset during RUN discards the operation and clears outputs.
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset lo", lo_out, 32'h0);
        check("midreset hi", hi_out, 32'h0);
        check("midreset done", {31'b0, done}, 32'h0);
        check("midreset dz", {31'b0, div_zero}, 32'h0);
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("midreset no done", 32'(pulses), 32'h0);
        issue(32'd9, 32'd3, lat);
        check("after reset latency", 32'(lat), 32'd33);
        check("after reset lo", lo_out, 32'd3);
        check("after reset hi", hi_out, 32'd0);
        @(negedge clock);

        // A second start and operand changes during RUN have no effect.
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        pulses = 0;
        got_lo = '0;
        got_hi = '0;
        repeat (80) begin
            @(negedge clock);
            if (done) begin
                pulses++;
                got_lo = lo_out;
                got_hi = hi_out;
            end
        end
        check("restart done count", 32'(pulses), 32'd1);
        check("restart lo", got_lo, 32'd333);
        check("restart hi", got_hi, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential 32-bit integer divider implementing the MIPS `div` instruction. The control unit launches it from the execute state of the multicycle CPU. It takes operands from the A/B registers and returns the quotient and remainder for the HI/LO registers. It is the inverse counterpart of the Booth multiplier and shares that block's start/done handshake, so both units plug into the same HI/LO write path.

## Interface
- `WIDTH`, default 32: operand and result width; only 32 is used in the CPU.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  launch request, sampled in IDLE only (Use_Div from control unit).
- `dividend`  in  WIDTH  numerator (RegA_Out), captured on the accepted start edge.
- `divisor`  in  WIDTH  denominator (RegB_Out), captured on the accepted start edge.
- `hi_out`  out  WIDTH  remainder; feeds HI_In.
- `lo_out`  out  WIDTH  quotient; feeds LO_In.
- `done`  out  1  one-cycle pulse; hi_out/lo_out valid, control unit asserts HILO_Write.
- `div_zero`  out  1  one-cycle pulse coincident with done when divisor was 0.
- `unsigned_op`  in  1  present only with SEQ_DIV_DIVU_EN (see Configuration).

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE with start=1 and divisor≠0:
  - Latch sign flags of the dividend and of the quotient (XOR of operand signs).
  - Load |dividend| into the quotient shift register and |divisor| into the divisor register.
  - Clear the 33-bit partial remainder and the counter, then go to RUN.
- IDLE with start=1 and divisor=0: assert done=1 and div_zero=1 next cycle, leave hi_out/lo_out unchanged, go to DONE.
- RUN performs one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem − divisor.
  - If the result is non-negative, take it as the new rem and set quo[0]=1; otherwise keep rem and set quo[0]=0.
  - Increment the counter. After WIDTH steps, go to FIX.
- FIX:
  - lo_out = quotient, negated (two's complement) if the quotient sign flag is set.
  - hi_out = remainder, negated if the dividend was negative.
  - Assert done=1 and go to DONE.
- DONE: deassert done/div_zero, return to IDLE.
- Arithmetic: the quotient truncates toward zero; the remainder takes the dividend's sign.
- Absolute values are unsigned WIDTH-bit, so |−2^31| = 0x80000000.
- The −2^31 / −1 overflow case yields LO=0x80000000, HI=0 and no flag.
- start is ignored in RUN, FIX and DONE; there is no queueing.
- Operands are captured once at start; later changes on dividend/divisor have no effect.
- hi_out/lo_out hold their value until the next FIX. Only FIX updates them.

## Timing
- Reset values: hi_out=0, lo_out=0, done=0, div_zero=0, state=IDLE, counter=0.
- Start accepted at edge E0.
  - Edges E1..E32 perform the 32 RUN steps.
  - Edge E33 executes FIX; done=1 during the cycle E33–E34.
  - Edge E34 is DONE→IDLE. A new start is accepted at E35 or later.
- Divide by zero: start at E0 gives done=div_zero=1 during E0–E1, and a new start is accepted at E2.
- Reset asserted mid-operation: immediate return to the reset values; any partial result is discarded and done is not pulsed.
- done and div_zero are registered outputs, with no combinational path from inputs.

## Configuration
- `SEQ_DIV_DIVU_EN` defined:
  - Adds the `unsigned_op` input, latched with start.
  - When `unsigned_op`=1, operands are used as-is, with no abs and no sign fix in FIX, implementing `divu`.
  - The div_zero behaviour is identical.
- `SEQ_DIV_DIVU_EN` undefined: the port is absent and all divisions are signed.

## Structure
- Package `seq_div_pkg` holds:
  - The state enum (IDLE, RUN, FIX, DONE).
  - The default WIDTH constant.
  - The counter width localparam, $clog2(WIDTH)+1.
- One sub-module, `seq_div_step`: combinational single restoring step. It takes {rem, quo} and the divisor and produces the next {rem, quo}. It is instantiated once inside the RUN datapath.

## Test plan
- 100 / 7 → after 33 cycles done=1, LO=0x0000000E, HI=0x00000002, div_zero=0.
- −100 (0xFFFFFF9C) / 7 → LO=0xFFFFFFF2, HI=0xFFFFFFFE. Also 100 / −7 → LO=0xFFFFFFF2, HI=0x00000002.
- Prior result LO=14, HI=2, then 5 / 0 → done=div_zero=1 the cycle after start; LO=14 and HI=2 retained; back in IDLE two cycles after start.
- 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Also 0 / 9 → LO=0, HI=0.
- Reset at cycle 10 of RUN for 1000/3 → outputs 0, no done pulse. A re-issued 9 / 3 gives LO=3, HI=0. A second start pulsed during RUN is ignored and exactly one done is observed.
- With SEQ_DIV_DIVU_EN: unsigned_op=1, 0xFFFFFFFF / 2 → LO=0x7FFFFFFF, HI=1. The same operands with unsigned_op=0 give LO=0, HI=0xFFFFFFFF.
